io_bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single device-control I/O bus among up to N_MASTERS issuing units (the device-control functional unit, plus DMA/debug masters). Grants one bus request at a time and tracks outstanding reads in an in-order ID queue. Routes each read response back to the master that issued it. Sits between the masters' bus-access logic and the I/O bus slave side.

---
 rtl/io_bus_arbiter_pkg.sv | 18 +
 rtl/io_bus_arbiter_if.sv | 38 +++
 rtl/io_bus_arbiter_id_fifo.sv | 63 ++++++
 rtl/io_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types for the device-control I/O bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//   master_id_t : requester index; sized for the largest supported master count
//   arb_state_t : arbiter FSM state
package io_bus_arbiter_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int MASTER_ID_W = $clog2(MAX_MASTERS);

  typedef logic [MASTER_ID_W-1:0] master_id_t;

  typedef enum logic {
    ARB   = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the issuing masters, the arbiter and the I/O bus slave.
// Latency: n/a (wires only).
// Backpressure: request side is req/ack; read data returns in order on rvalid.
//   m_*   : per-master request, payload, ack and read-return signals
//   s_*   : single shared I/O bus towards the slave
//   master: view taken by the arbiter, which masters the I/O bus
//   slave : view taken by the environment (issuing units plus bus slave)
interface io_bus_arbiter_if #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_MASTERS-1:0]                 m_req;
  logic [N_MASTERS-1:0]                 m_we;
  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata;
  logic [N_MASTERS-1:0]                 m_ack;
  logic [N_MASTERS-1:0]                 m_rvalid;
  logic [DATA_WIDTH-1:0]                m_rdata;

  logic                  s_req;
  logic                  s_we;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_ack;
  logic                  s_rvalid;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport master (
    input  m_req, m_we, m_addr, m_wdata, s_ack, s_rvalid, s_rdata,
    output m_ack, m_rvalid, m_rdata, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    output m_req, m_we, m_addr, m_wdata, s_ack, s_rvalid, s_rdata,
    input  m_ack, m_rvalid, m_rdata, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/io_bus_arbiter_id_fifo.sv
// In-order queue of master IDs for reads awaiting a response.
// Latency: pushed entry visible at dout one cycle after push when queue was empty.
// Backpressure: push ignored when full unless a pop frees the slot the same cycle.
//   push/din : enqueue an ID      pop/dout : dequeue head (dout = current head)
//   count    : entries held (0..DEPTH)     empty/full : status flags
module io_bus_arbiter_id_fifo
  import io_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  master_id_t              din,
  output master_id_t              dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  master_id_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // When full, the write lands in the slot the simultaneous pop releases.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for the device-control I/O bus with in-order read-ID tracking.
// Latency: m_req -> s_req 1 cycle; s_ack -> m_ack and s_rvalid -> m_rvalid combinational.
// Backpressure: owner held until s_ack; reads not granted while MAX_OUTSTANDING in flight.
//   clk/reset            : single clock, synchronous active-high reset
//   bus                  : master modport of io_bus_arbiter_if (masters + slave bus)
//   o_outstanding        : reads in flight
//   o_idle               : no owner, no reads in flight, no m_req asserted
//   o_err_unexpected_rsp : sticky, s_rvalid arrived with nothing in flight
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  io_bus_arbiter_if.master                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]  o_outstanding,
  output logic                              o_idle,
  output logic                              o_err_unexpected_rsp
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_t            r_state;
  master_id_t            r_owner;
  master_id_t            r_rr_ptr;
  logic                  r_s_req;
  logic                  r_err;

  logic [N_MASTERS-1:0]  w_elig;
  logic                  w_hi_vld, w_lo_vld, w_pick_vld;
  master_id_t            w_hi_id, w_lo_id, w_pick;
  logic                  w_s_we;
  logic [ADDR_WIDTH-1:0] w_s_addr;
  logic [DATA_WIDTH-1:0] w_s_wdata;
  logic                  w_push, w_pop;
  logic                  w_q_empty, w_q_full;
  master_id_t            w_q_head;
  logic [CNT_W-1:0]      w_q_count;

  // Writes never occupy a queue slot, so only reads are held back when full.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_elig[i] = bus.m_req[i] & (bus.m_we[i] | ~w_q_full);
    end
  end

  // Round-robin: lowest eligible index at or above rr_ptr, else lowest overall (wrap).
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_id  = '0;
    w_lo_vld = 1'b0;
    w_lo_id  = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_vld = 1'b1;
        w_lo_id  = master_id_t'(i);
        if (master_id_t'(i) >= r_rr_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_id  = master_id_t'(i);
        end
      end
    end
  end

  assign w_pick_vld = w_lo_vld;
  assign w_pick     = w_hi_vld ? w_hi_id : w_lo_id;

  // Owner payload straight onto the bus.
  always_comb begin
    w_s_we    = 1'b0;
    w_s_addr  = '0;
    w_s_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_owner == master_id_t'(i)) begin
        w_s_we    = bus.m_we[i];
        w_s_addr  = bus.m_addr[i];
        w_s_wdata = bus.m_wdata[i];
      end
    end
  end

  assign w_push = r_s_req & bus.s_ack & ~w_s_we;
  assign w_pop  = bus.s_rvalid & ~w_q_empty;

  always_comb begin
    bus.m_ack    = '0;
    bus.m_rvalid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      bus.m_ack[i]    = r_s_req & bus.s_ack & (r_owner == master_id_t'(i));
      bus.m_rvalid[i] = w_pop & (w_q_head == master_id_t'(i));
    end
  end

  assign bus.m_rdata = bus.s_rdata;
  assign bus.s_req   = r_s_req;
  assign bus.s_we    = w_s_we;
  assign bus.s_addr  = w_s_addr;
  assign bus.s_wdata = w_s_wdata;

  io_bus_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_owner),
    .dout  (w_q_head),
    .count (w_q_count),
    .empty (w_q_empty),
    .full  (w_q_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_s_req  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (bus.s_rvalid & w_q_empty) r_err <= 1'b1;
      case (r_state)
        ARB: begin
          if (w_pick_vld) begin
            r_owner <= w_pick;
            r_s_req <= 1'b1;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (bus.s_ack) begin
            r_rr_ptr <= (r_owner == master_id_t'(N_MASTERS - 1)) ? '0 : r_owner + 1'b1;
            r_s_req  <= 1'b0;
            r_state  <= ARB;
          end
        end
        default: begin
          r_s_req <= 1'b0;
          r_state <= ARB;
        end
      endcase
    end
  end

  assign o_outstanding        = w_q_count;
  assign o_idle               = (r_state == ARB) & w_q_empty & ~(|bus.m_req);
  assign o_err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed table, corner-case sequences, random traffic.
// Latency: n/a.
// Backpressure: masters hold m_req and payload until their m_ack.
module tb_io_bus_arbiter;
  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] outstanding;
  logic       idle;
  logic       err;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  io_bus_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .o_outstanding        (outstanding),
    .o_idle               (idle),
    .o_err_unexpected_rsp (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the bus, round-robin start, queue of read issuers.
  bit           md_owned;
  int           md_owner;
  int           md_rr;
  int           md_q[$];
  bit           md_err;
  logic [N-1:0] exp_mack;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic         ack;
    logic         rv;
    logic [31:0]  rdata;
    logic         e_sreq;
    logic [N-1:0] e_mack;
    logic [N-1:0] e_mrv;
    int           e_out;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] we,
                       input logic ack, input logic rv, input logic [31:0] rdata);
    bus.m_req    = req;
    bus.m_we     = we;
    bus.s_ack    = ack;
    bus.s_rvalid = rv;
    bus.s_rdata  = rdata;
  endtask

  task automatic model_reset();
    md_owned = 1'b0;
    md_owner = 0;
    md_rr    = 0;
    md_q.delete();
    md_err   = 1'b0;
  endtask

  // Compare every output against the model for the inputs currently driven.
  task automatic settle_check();
    logic [N-1:0] e_mack;
    logic [N-1:0] e_mrv;
    #1;
    e_mack = (md_owned && bus.s_ack) ? (N'(1) << md_owner) : '0;
    e_mrv  = (bus.s_rvalid && md_q.size() > 0) ? (N'(1) << md_q[0]) : '0;
    chk("s_req", bus.s_req, md_owned);
    chk("m_ack", bus.m_ack, e_mack);
    chk("m_rvalid", bus.m_rvalid, e_mrv);
    if (e_mrv != '0) chk("m_rdata", bus.m_rdata, bus.s_rdata);
    chk("outstanding", outstanding, md_q.size());
    chk("idle", idle, !md_owned && md_q.size() == 0 && bus.m_req == '0);
    chk("err", err, md_err);
    if (md_owned) begin
      chk("s_we", bus.s_we, bus.m_we[md_owner]);
      chk("s_addr", bus.s_addr, bus.m_addr[md_owner]);
      chk("s_wdata", bus.s_wdata, bus.m_wdata[md_owner]);
      if (!bus.m_req[md_owner]) begin
        errors++;
        $display("FAIL protocol: m_req[%0d] dropped while owned", md_owner);
      end
    end
    exp_mack = e_mack;
  endtask

  // Advance the model by one clock with the current inputs, then move to the next negedge.
  task automatic adv();
    bit push, pop, found;
    int idx;
    if (reset) begin
      model_reset();
    end else begin
      push = md_owned && bus.s_ack && !bus.m_we[md_owner];
      pop  = bus.s_rvalid && md_q.size() > 0;
      if (bus.s_rvalid && md_q.size() == 0) md_err = 1'b1;
      if (md_owned) begin
        if (bus.s_ack) begin
          md_rr    = (md_owner + 1) % N;
          md_owned = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (md_rr + k) % N;
          if (!found && bus.m_req[idx] && (bus.m_we[idx] || md_q.size() < MAXO)) begin
            found    = 1'b1;
            md_owner = idx;
            md_owned = 1'b1;
          end
        end
      end
      if (pop)  void'(md_q.pop_front());
      if (push) md_q.push_back(md_owner);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] pend;
    int           ilv_id[3];
    logic [31:0]  ilv_dat[3];

    // Directed table: single read then two masters alternating writes.
    vt[0]  = '{3'b001, 3'b000, 1'b0, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[1]  = '{3'b001, 3'b000, 1'b0, 1'b0, 32'h0,    1'b1, 3'b000, 3'b000, 0};
    vt[2]  = '{3'b001, 3'b000, 1'b0, 1'b0, 32'h0,    1'b1, 3'b000, 3'b000, 0};
    vt[3]  = '{3'b001, 3'b000, 1'b1, 1'b0, 32'h0,    1'b1, 3'b001, 3'b000, 0};
    vt[4]  = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 1};
    vt[5]  = '{3'b000, 3'b000, 1'b0, 1'b1, 32'hCAFE, 1'b0, 3'b000, 3'b001, 1};
    vt[6]  = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[7]  = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[8]  = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b1, 3'b010, 3'b000, 0};
    vt[9]  = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[10] = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b1, 3'b001, 3'b000, 0};
    vt[11] = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[12] = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b1, 3'b010, 3'b000, 0};
    vt[13] = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};
    vt[14] = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h0,    1'b1, 3'b001, 3'b000, 0};
    vt[15] = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,    1'b0, 3'b000, 3'b000, 0};

    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++) begin
      bus.m_addr[i]  = 32'h10 * (i + 1);
      bus.m_wdata[i] = 32'hD0 + i;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].req, vt[i].we, vt[i].ack, vt[i].rv, vt[i].rdata);
      settle_check();
      chk($sformatf("tbl%0d_s_req", i), bus.s_req, vt[i].e_sreq);
      chk($sformatf("tbl%0d_m_ack", i), bus.m_ack, vt[i].e_mack);
      chk($sformatf("tbl%0d_m_rvalid", i), bus.m_rvalid, vt[i].e_mrv);
      chk($sformatf("tbl%0d_outstanding", i), outstanding, vt[i].e_out);
      if (vt[i].e_mrv != '0) chk($sformatf("tbl%0d_m_rdata", i), bus.m_rdata, vt[i].rdata);
      adv();
    end

    // Fill the read queue from master 0.
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
      settle_check();
      adv();
    end
    drive('0, '0, 1'b0, 1'b0, '0);
    settle_check();
    chk("full_out", outstanding, 4);
    adv();
    // Fifth read blocked; write from master 1 still goes through.
    drive(3'b011, 3'b010, 1'b1, 1'b0, '0);
    settle_check();
    chk("full_arb_sreq", bus.s_req, 0);
    adv();
    settle_check();
    chk("full_m1_write_ack", bus.m_ack, 3'b010);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
      settle_check();
      chk("full_read_blocked", bus.s_req, 0);
      adv();
    end
    drive(3'b001, 3'b000, 1'b1, 1'b1, 32'h55);
    settle_check();
    chk("full_pop_rvalid", bus.m_rvalid, 3'b001);
    chk("full_pop_sreq", bus.s_req, 0);
    adv();
    drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
    settle_check();
    chk("after_pop_out", outstanding, 3);
    chk("after_pop_sreq", bus.s_req, 0);
    adv();
    settle_check();
    chk("fifth_read_sreq", bus.s_req, 1);
    chk("fifth_read_ack", bus.m_ack, 3'b001);
    adv();

    // Read accepted in the same cycle a response pops.
    drive('0, '0, 1'b0, 1'b1, 32'h66);
    settle_check();
    chk("simul_pre_pop", bus.m_rvalid, 3'b001);
    adv();
    drive(3'b010, 3'b000, 1'b0, 1'b0, '0);
    settle_check();
    adv();
    drive(3'b010, 3'b000, 1'b1, 1'b1, 32'h77);
    settle_check();
    chk("simul_ack", bus.m_ack, 3'b010);
    chk("simul_rvalid", bus.m_rvalid, 3'b001);
    adv();
    drive('0, '0, 1'b0, 1'b0, '0);
    settle_check();
    chk("simul_out", outstanding, 3);
    chk("simul_err", err, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive('0, '0, 1'b0, 1'b1, 32'h100 + i);
      settle_check();
      adv();
    end

    // Interleaved routing: reads m1, m0, m1 answered A, B, C.
    ilv_id[0] = 1;  ilv_id[1] = 0;  ilv_id[2] = 1;
    ilv_dat[0] = 32'hA; ilv_dat[1] = 32'hB; ilv_dat[2] = 32'hC;
    for (int k = 0; k < 3; k++) begin
      drive(N'(1) << ilv_id[k], '0, 1'b1, 1'b0, '0);
      settle_check();
      adv();
      settle_check();
      chk("ilv_ack", bus.m_ack, N'(1) << ilv_id[k]);
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      drive('0, '0, 1'b0, 1'b1, ilv_dat[k]);
      settle_check();
      chk("ilv_rvalid", bus.m_rvalid, N'(1) << ilv_id[k]);
      chk("ilv_rdata", bus.m_rdata, ilv_dat[k]);
      adv();
    end

    // Unexpected response, then reset while a master owns the bus.
    drive('0, '0, 1'b0, 1'b1, 32'hBAD);
    settle_check();
    chk("unexp_rvalid", bus.m_rvalid, 0);
    adv();
    drive('0, '0, 1'b0, 1'b0, '0);
    settle_check();
    chk("err_set", err, 1);
    adv();
    drive(3'b001, 3'b000, 1'b1, 1'b0, '0);
    settle_check();
    adv();
    settle_check();
    adv();
    drive(3'b001, 3'b000, 1'b0, 1'b0, '0);
    settle_check();
    adv();
    reset = 1'b1;
    settle_check();
    chk("pre_reset_sreq", bus.s_req, 1);
    chk("pre_reset_out", outstanding, 1);
    adv();
    reset = 1'b0;
    drive('0, '0, 1'b0, 1'b0, '0);
    settle_check();
    chk("rst_sreq", bus.s_req, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    adv();

    // Random traffic; masters hold requests until acknowledged.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]        = 1'b1;
          bus.m_we[i]    = 1'($urandom_range(0, 1));
          bus.m_addr[i]  = $urandom;
          bus.m_wdata[i] = $urandom;
        end
      end
      bus.m_req    = pend;
      bus.s_ack    = 1'($urandom_range(0, 1));
      bus.s_rvalid = (md_q.size() > 0) && ($urandom_range(0, 4) < 2);
      bus.s_rdata  = $urandom;
      settle_check();
      pend = pend & ~exp_mack;
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
